// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath, with a retire counter and sticky illegal-instruction / bus-timeout traps.
module multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic [1:0]       mem_size,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             alu_a_sel,
   output logic             alu_b_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            state_q;
   state_t            state_n;
   logic [WAIT_W-1:0] wait_cnt;
   logic              retire;
   logic              set_illegal;
   logic              set_bus_err;
   logic              legal;
   logic              is_store;

   assign is_store = (opcode == OPC_STORE);
   assign state_o  = state_q;

   always_comb begin
      legal = 1'b0;
      if (opcode[1:0] == 2'b11) begin
         unique case (opcode)
            OPC_OP, OPC_IMM, OPC_JAL,
            OPC_LUI, OPC_AUIPC: legal = 1'b1;
            OPC_LOAD:           legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            OPC_STORE:          legal = (funct3 <= 3'd2);
            OPC_BRANCH:         legal = (funct3 != 3'd2) && (funct3 != 3'd3);
            OPC_JALR:           legal = (funct3 == 3'd0);
            default:            legal = 1'b0;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path leaves a latch behind.
   always_comb begin
      state_n      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      mem_size     = 2'b00;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      retire       = 1'b0;
      set_illegal  = 1'b0;
      set_bus_err  = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_size = 2'b10;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_n = S_EXEC;
            end else begin
               state_n     = S_TRAP;
               set_illegal = 1'b1;
            end
         end
         S_EXEC: begin
            state_n = S_WB;
            unique case (opcode)
               OPC_IMM, OPC_JALR:   alu_b_sel = 1'b1;
               OPC_LOAD, OPC_STORE: begin
                  alu_b_sel = 1'b1;
                  state_n   = S_MEM;
               end
               OPC_AUIPC: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = 1'b1;
               end
               OPC_BRANCH: begin
                  pc_we   = 1'b1;
                  pc_src  = branch_taken ? 2'd1 : 2'd0;
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            // Operands stay on rs1+imm so the ALU keeps presenting the address.
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            mem_size     = funct3[1:0];
            alu_b_sel    = 1'b1;
            if (mem_ready) begin
               if (is_store) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_n = S_FETCH;
            unique case (opcode)
               OPC_LOAD:           wb_sel = 2'd1;
               OPC_JAL, OPC_JALR:  wb_sel = 2'd2;
               OPC_LUI:            wb_sel = 2'd3;
               default:            wb_sel = 2'd0;
            endcase
            if (opcode == OPC_JAL) begin
               pc_src = 2'd1;
            end else if (opcode == OPC_JALR) begin
               pc_src = 2'd2;
            end
         end
         S_TRAP: ;
         default: state_n = S_TRAP;
      endcase

      // A ready arriving in the final allowed cycle still completes the access.
      if ((MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_cnt == LAST_WAIT)) begin
         state_n     = S_TRAP;
         set_bus_err = 1'b1;
      end

      if (rst) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         mem_size     = 2'b00;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         pc_src       = 2'd0;
         reg_we       = 1'b0;
         wb_sel       = 2'd0;
         alu_a_sel    = 1'b0;
         alu_b_sel    = 1'b0;
         retire       = 1'b0;
         set_illegal  = 1'b0;
         set_bus_err  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_FETCH;
         instret  <= '0;
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_n;
         if (retire)      instret <= instret + CNT_W'(1);
         if (set_illegal) illegal <= 1'b1;
         if (set_bus_err) bus_err <= 1'b1;
         if ((state_n != state_q) && ((state_n == S_FETCH) || (state_n == S_MEM))) begin
            wait_cnt <= '0;
         end else if (mem_req) begin
            wait_cnt <= mem_ready ? '0 : wait_cnt + WAIT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle outputs, then a single loop drives and compares them.
module tb_multicycle_ctrl;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_BADLOW = 7'b0110001;

   localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
   localparam logic [2:0] ST_MEM   = 3'd3, ST_WB     = 3'd4, ST_TRAP = 3'd5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [6:0]       opcode = '0;
   logic [2:0]       funct3 = '0;
   logic             branch_taken = 1'b0;
   logic             mem_ready = 1'b0;
   logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
   logic             alu_a_sel, alu_b_sel, illegal, bus_err;
   logic [1:0]       mem_size, pc_src, wb_sel;
   logic [2:0]       state_o;
   logic [CNT_W-1:0] instret;

   multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .mem_size(mem_size),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .illegal(illegal), .bus_err(bus_err),
      .state_o(state_o), .instret(instret)
   );

   always #5 clk = ~clk;

   // One expected cycle: inputs to apply plus outputs the DUT must show.
   typedef struct {
      logic       rst, ready, taken;
      logic [6:0] op;
      logic [2:0] f3;
      logic [2:0] st;
      logic [4:0] strb;   // {mem_req, mem_we, ir_we, pc_we, reg_we}
      logic       addr_sel;
      logic [1:0] size, pc_src, wb_sel;
      logic       a_sel, b_sel;
      logic       retire, set_ill, set_berr, clr;
   } cyc_t;

   cyc_t             q[$];
   logic [6:0]       cur_op = '0;
   logic [2:0]       cur_f3 = '0;
   logic [2:0]       tail_st = ST_FETCH;
   logic [CNT_W-1:0] exp_instret = '0;
   logic             exp_ill = 1'b0;
   logic             exp_berr = 1'b0;
   int               n_checks = 0;
   int               n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         OPC_OP, OPC_IMM, OPC_JAL, OPC_LUI, OPC_AUIPC: return 1'b1;
         OPC_LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
         OPC_STORE:  return f3 <= 3'd2;
         OPC_BRANCH: return !(f3 inside {3'd2, 3'd3});
         OPC_JALR:   return f3 == 3'd0;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] pick_f3(input logic [6:0] op);
      logic [2:0] f;
      do f = 3'($urandom); while (!legal(op, f));
      return f;
   endfunction

   function automatic cyc_t blank(input logic [2:0] st);
      cyc_t e;
      e       = '{default: '0};
      e.st    = st;
      e.op    = cur_op;
      e.f3    = cur_f3;
      e.ready = 1'($urandom);
      e.taken = 1'($urandom);
      return e;
   endfunction

   task automatic push_trap(input int n);
      for (int i = 0; i < n; i++) q.push_back(blank(ST_TRAP));
      tail_st = ST_TRAP;
   endtask

   task automatic push_reset();
      cyc_t e;
      e     = blank(tail_st);
      e.rst = 1'b1;
      e.clr = 1'b1;
      q.push_back(e);
      tail_st = ST_FETCH;
   endtask

   // A request waits `waits` cycles before ready; the MEM_TIMEOUT-th idle cycle traps instead.
   task automatic push_access(input logic [2:0] st, input int waits, input bit store,
                              output bit ok, output cyc_t done);
      cyc_t e;
      e = blank(st);
      if (st == ST_FETCH) begin
         e.strb = 5'b10000;
         e.size = 2'b10;
      end else begin
         e.strb     = {1'b1, store, 3'b000};
         e.addr_sel = 1'b1;
         e.size     = cur_f3[1:0];
         e.b_sel    = 1'b1;
      end
      for (int i = 0; i < waits && i < MEM_TIMEOUT; i++) begin
         e.ready    = 1'b0;
         e.set_berr = (i == MEM_TIMEOUT - 1);
         q.push_back(e);
      end
      ok         = waits < MEM_TIMEOUT;
      e.ready    = 1'b1;
      e.set_berr = 1'b0;
      done       = e;
      if (!ok) push_trap(3);
   endtask

   task automatic build_instr(input logic [6:0] op, input logic [2:0] f3,
                              input int wf, input int wm, input bit taken);
      cyc_t e;
      bit   ok;
      cur_op = op;
      cur_f3 = f3;
      push_access(ST_FETCH, wf, 1'b0, ok, e);
      if (!ok) return;
      e.strb[2] = 1'b1;
      q.push_back(e);
      e = blank(ST_DECODE);
      if (!legal(op, f3)) begin
         e.set_ill = 1'b1;
         q.push_back(e);
         push_trap(10);
         return;
      end
      q.push_back(e);
      e = blank(ST_EXEC);
      tail_st = ST_FETCH;
      case (op)
         OPC_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: e.b_sel = 1'b1;
         OPC_AUIPC: begin e.a_sel = 1'b1; e.b_sel = 1'b1; end
         OPC_BRANCH: begin
            e.taken  = taken;
            e.strb   = 5'b00010;
            e.pc_src = {1'b0, taken};
            e.retire = 1'b1;
         end
         default: ;
      endcase
      q.push_back(e);
      if (op == OPC_BRANCH) return;
      if (op == OPC_LOAD || op == OPC_STORE) begin
         push_access(ST_MEM, wm, op == OPC_STORE, ok, e);
         if (!ok) return;
         if (op == OPC_STORE) begin
            e.strb[1] = 1'b1;
            e.retire  = 1'b1;
            q.push_back(e);
            return;
         end
         q.push_back(e);
      end
      e        = blank(ST_WB);
      e.strb   = 5'b00011;
      e.retire = 1'b1;
      e.wb_sel = (op == OPC_LOAD) ? 2'd1 : (op == OPC_JAL || op == OPC_JALR) ? 2'd2 :
                 (op == OPC_LUI) ? 2'd3 : 2'd0;
      e.pc_src = (op == OPC_JAL) ? 2'd1 : (op == OPC_JALR) ? 2'd2 : 2'd0;
      q.push_back(e);
   endtask

   // Entered and left at posedge+1: drive, compare at negedge, advance the model.
   task automatic run_queue();
      cyc_t e;
      while (q.size() > 0) begin
         e            = q.pop_front();
         rst          = e.rst;
         opcode       = e.op;
         funct3       = e.f3;
         mem_ready    = e.ready;
         branch_taken = e.taken;
         @(negedge clk);
         check("state", 32'(state_o), 32'(e.st));
         check("strobes", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'(e.strb));
         check("selects", 32'({mem_addr_sel, mem_size, pc_src, wb_sel, alu_a_sel, alu_b_sel}),
               32'({e.addr_sel, e.size, e.pc_src, e.wb_sel, e.a_sel, e.b_sel}));
         check("instret", 32'(instret), 32'(exp_instret));
         check("flags", 32'({illegal, bus_err}), 32'({exp_ill, exp_berr}));
         if (e.retire)   exp_instret++;
         if (e.set_ill)  exp_ill = 1'b1;
         if (e.set_berr) exp_berr = 1'b1;
         if (e.clr) begin
            exp_instret = '0;
            exp_ill     = 1'b0;
            exp_berr    = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   logic [6:0] ops [12] = '{OPC_OP, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_FENCE, OPC_BADLOW};

   initial begin
      logic [6:0] op;
      logic [2:0] f3;
      int         wf, wm;

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'(state_o), 32'(ST_FETCH));
      check("reset_strobes", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'd0);
      check("reset_instret", 32'(instret), 32'd0);
      check("reset_flags", 32'({illegal, bus_err}), 32'd0);

      build_instr(OPC_IMM, 3'd0, 0, 0, 1'b0);
      check("addi_cycles", 32'(q.size()), 32'd4);
      run_queue();
      check("addi_instret", 32'(instret), 32'd1);

      build_instr(OPC_LOAD, 3'd2, 2, 0, 1'b0);
      check("lw_cycles", 32'(q.size()), 32'd7);
      run_queue();
      check("lw_instret", 32'(instret), 32'd2);

      build_instr(OPC_BRANCH, 3'd0, 0, 0, 1'b1);
      check("beq_t_cycles", 32'(q.size()), 32'd3);
      build_instr(OPC_BRANCH, 3'd0, 0, 0, 1'b0);
      check("beq_nt_cycles", 32'(q.size()), 32'd6);
      build_instr(OPC_STORE, 3'd1, 0, 1, 1'b0);
      run_queue();
      check("beq_sh_instret", 32'(instret), 32'd5);

      build_instr(OPC_SYSTEM, 3'd0, 0, 0, 1'b0);
      run_queue();
      check("system_illegal", 32'(illegal), 32'd1);
      check("system_state", 32'(state_o), 32'(ST_TRAP));
      check("system_instret", 32'(instret), 32'd5);
      push_reset();

      build_instr(OPC_IMM, 3'd0, 5, 0, 1'b0);
      run_queue();
      check("fetch_timeout_berr", 32'(bus_err), 32'd1);
      check("fetch_timeout_state", 32'(state_o), 32'(ST_TRAP));
      push_reset();

      build_instr(OPC_IMM, 3'd0, 3, 0, 1'b0);
      run_queue();
      check("ready_4th_berr", 32'(bus_err), 32'd0);
      check("ready_4th_instret", 32'(instret), 32'd1);

      build_instr(OPC_LOAD, 3'd0, 0, 6, 1'b0);
      run_queue();
      check("mem_timeout_berr", 32'(bus_err), 32'd1);
      push_reset();

      for (int i = 0; i < 16; i++) build_instr(OPC_OP, 3'd0, 0, 0, 1'b0);
      run_queue();
      check("wrap_instret", 32'(instret), 32'd0);

      build_instr(OPC_LUI, 3'd0, 0, 0, 1'b0);
      cur_op = OPC_LOAD;
      cur_f3 = 3'd2;
      begin
         cyc_t e;
         bit   ok;
         push_access(ST_FETCH, 0, 1'b0, ok, e);
         e.strb[2] = 1'b1;
         q.push_back(e);
         q.push_back(blank(ST_DECODE));
         e       = blank(ST_EXEC);
         e.b_sel = 1'b1;
         q.push_back(e);
         push_access(ST_MEM, 1, 1'b0, ok, e);
         tail_st = ST_MEM;
         push_reset();
      end
      run_queue();
      check("rst_mem_state", 32'(state_o), 32'(ST_FETCH));
      check("rst_mem_instret", 32'(instret), 32'd0);
      check("rst_mem_flags", 32'({illegal, bus_err}), 32'd0);

      for (int n = 0; n < 250; n++) begin
         op = ($urandom_range(0, 9) == 0) ? ops[$urandom_range(9, 11)] : ops[$urandom_range(0, 8)];
         f3 = 3'($urandom);
         if (op != OPC_SYSTEM && op != OPC_FENCE && op != OPC_BADLOW && $urandom_range(0, 5) != 0)
            f3 = pick_f3(op);
         wf = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
         wm = ($urandom_range(0, 24) == 0) ? MEM_TIMEOUT : $urandom_range(0, 3);
         build_instr(op, f3, wf, wm, 1'($urandom));
         if (tail_st == ST_TRAP) push_reset();
         run_queue();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
